cc_collision_checker: RTL
=========================

Name: cc_collision_checker

Overview:
- Consumer-side counterpart of the obstacle/point row merge used by the LED-matrix game. The merge ORs the obstacle and player layers for display; this block reads the same two layers row by row and ANDs them to detect overlap.
- It scans all matrix rows after a start request, reports whether any player pixel coincides with an obstacle pixel, and records the first colliding row and the total overlapping pixel count.
- It holds a sticky game-over flag for the game controller FSM.

Parameters:
- NUMBER_DATAWIDTH, 8, row width in pixels (obstacle/point bus width).
- NUMBER_ROWS, 8, number of matrix rows scanned.
- NUMBER_ADDRWIDTH, 3, row address width; must satisfy 2^NUMBER_ADDRWIDTH >= NUMBER_ROWS.
- NUMBER_COUNTWIDTH, 7, hit-count width; must hold NUMBER_ROWS*NUMBER_DATAWIDTH (64).

Ports:
- CC_COLLISION_CLOCK_50  in  1  system clock; all state updates on the rising edge.
- CC_COLLISION_RESET_InLow  in  1  asynchronous, active-low reset.
- CC_COLLISION_start_InHigh  in  1  scan request; sampled only in IDLE.
- CC_COLLISION_clear_InHigh  in  1  clears the sticky game-over flag.
- CC_COLLISION_obs_InBUS  in  8  obstacle row data for the row at rowAddr; combinational source, same cycle.
- CC_COLLISION_point_InBUS  in  8  player row data for the row at rowAddr; combinational source, same cycle.
- CC_COLLISION_rowAddr_OutBUS  out  3  row currently being read.
- CC_COLLISION_busy_OutHigh  out  1  high while in SCAN.
- CC_COLLISION_done_OutHigh  out  1  one-cycle pulse; result outputs updated this cycle.
- CC_COLLISION_hit_OutHigh  out  1  last scan found at least one overlap.
- CC_COLLISION_hitRow_OutBUS  out  3  lowest row index with overlap in last scan; 0 if none.
- CC_COLLISION_hitCount_OutBUS  out  7  number of overlapping pixels in last scan.
- CC_COLLISION_gameOver_OutHigh  out  1  sticky; set by any hit, cleared by clear.

Behaviour:
- Reset (async, RESET_InLow=0): state=IDLE; rowAddr=0, busy=0, done=0, hit=0, hitRow=0, hitCount=0, gameOver=0; internal accumulators=0. Reset asserted mid-scan aborts the scan with no done pulse.
- FSM states: IDLE, SCAN, DONE.
  - IDLE: rowAddr=0. If start=1 at edge T: go to SCAN; clear accumulators (acc_hit=0, acc_row=0, acc_cnt=0).
  - SCAN: busy=1. Each cycle, ovl = obs & point.
    - If ovl != 0 and acc_hit=0: acc_row <= rowAddr.
    - If ovl != 0: acc_hit <= 1.
    - acc_cnt <= acc_cnt + popcount(ovl), zero-extended to NUMBER_COUNTWIDTH; no overflow possible.
    - If rowAddr = NUMBER_ROWS-1: go to DONE, else rowAddr <= rowAddr+1.
  - DONE (one cycle): done=1, busy=0; hit/hitRow/hitCount were loaded from the accumulators on the edge entering DONE. Next state is IDLE.
- Timing: start sampled at edge T; rows 0..7 are presented during cycles T+1..T+8; done=1 during cycle T+9. Start-to-done latency is 9 cycles. The next start is accepted at the edge ending cycle T+10 (first IDLE cycle).
- Start is ignored in SCAN and DONE; it is not queued. Start held high continuously yields back-to-back scans, one every 10 cycles.
- Result outputs hold their values until the next DONE. No hit in a scan gives hit=0, hitRow=0, hitCount=0.
- gameOver:
  - Set on the edge entering DONE when acc_hit=1.
  - Cleared on any edge where clear=1.
  - If clear=1 and a hit is published on the same edge, set wins (gameOver=1).
  - clear does not affect hit/hitRow/hitCount.
- Input row data changing mid-scan is used as presented; no snapshotting.

Test Plan:
- Reset then idle: RESET_InLow 0→1, no start for 20 cycles → all outputs 0, rowAddr stays 0, no done pulse.
- No collision: obs row3=8'h18, point row6=8'h01, all other rows 0; pulse start → done exactly 9 cycles after start edge; hit=0, hitRow=0, hitCount=0, gameOver=0; busy high for exactly 8 cycles.
- Multi-row collision: obs row2=8'hF0 with point row2=8'h30 (2 overlaps); obs row5=8'hFF with point row5=8'h81 (2 overlaps) → hit=1, hitRow=2, hitCount=4, gameOver=1.
- Full overlap boundary: obs=point=8'hFF on all rows → hitCount=64 (7'b1000000), hitRow=0.
- Sticky and clear race: after a hit, assert clear on the same edge as the next hit scan's DONE → gameOver stays 1; then clear alone → gameOver=0 while hit remains 1. Start pulsed during SCAN is ignored (exactly one done pulse).
- Reset mid-scan: assert RESET_InLow=0 when rowAddr=4 → outputs immediately 0, state IDLE, no done pulse. A new start after release produces a correct full 8-row scan.

Source files
------------

// File: rtl/cc_collision_checker.sv
// ---------------------------------------------------------------------------
// cc_collision_checker
//
// Purpose:
//   Scans every row of the LED matrix after a start request. For each row it
//   ANDs the obstacle layer with the player layer to find overlapping pixels.
//   At the end of a scan it publishes:
//     - whether any overlap was seen,
//     - the lowest row that overlapped,
//     - the total number of overlapping pixels.
//   A sticky game-over flag is set by any hit and is released only by
//   clear. This block is the consumer-side counterpart of the row merge,
//   which ORs the same two layers for display.
//
// Ports:
//   CC_COLLISION_CLOCK_50         in   system clock, rising edge
//   CC_COLLISION_RESET_InLow      in   asynchronous active-low reset
//   CC_COLLISION_start_InHigh     in   scan request, sampled only in IDLE
//   CC_COLLISION_clear_InHigh     in   clears the sticky game-over flag
//   CC_COLLISION_obs_InBUS        in   obstacle row data for rowAddr
//   CC_COLLISION_point_InBUS      in   player row data for rowAddr
//   CC_COLLISION_rowAddr_OutBUS   out  row currently being read
//   CC_COLLISION_busy_OutHigh     out  high while scanning
//   CC_COLLISION_done_OutHigh     out  one-cycle pulse, results valid
//   CC_COLLISION_hit_OutHigh      out  last scan found an overlap
//   CC_COLLISION_hitRow_OutBUS    out  lowest overlapping row (0 if none)
//   CC_COLLISION_hitCount_OutBUS  out  overlapping pixel count of last scan
//   CC_COLLISION_gameOver_OutHigh out  sticky game-over flag
// ---------------------------------------------------------------------------
module cc_collision_checker #(
  parameter int NUMBER_DATAWIDTH  = 8,
  parameter int NUMBER_ROWS       = 8,
  parameter int NUMBER_ADDRWIDTH  = 3,
  parameter int NUMBER_COUNTWIDTH = 7
) (
  input  logic                         CC_COLLISION_CLOCK_50,
  input  logic                         CC_COLLISION_RESET_InLow,
  input  logic                         CC_COLLISION_start_InHigh,
  input  logic                         CC_COLLISION_clear_InHigh,
  input  logic [NUMBER_DATAWIDTH-1:0]  CC_COLLISION_obs_InBUS,
  input  logic [NUMBER_DATAWIDTH-1:0]  CC_COLLISION_point_InBUS,
  output logic [NUMBER_ADDRWIDTH-1:0]  CC_COLLISION_rowAddr_OutBUS,
  output logic                         CC_COLLISION_busy_OutHigh,
  output logic                         CC_COLLISION_done_OutHigh,
  output logic                         CC_COLLISION_hit_OutHigh,
  output logic [NUMBER_ADDRWIDTH-1:0]  CC_COLLISION_hitRow_OutBUS,
  output logic [NUMBER_COUNTWIDTH-1:0] CC_COLLISION_hitCount_OutBUS,
  output logic                         CC_COLLISION_gameOver_OutHigh
);

  localparam logic [NUMBER_ADDRWIDTH-1:0] LAST_ROW = NUMBER_ADDRWIDTH'(NUMBER_ROWS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                        state;
  state_t                        state_next;

  logic [NUMBER_ADDRWIDTH-1:0]   row_addr;
  logic [NUMBER_ADDRWIDTH-1:0]   row_addr_next;

  logic                          acc_hit;
  logic                          acc_hit_next;
  logic [NUMBER_ADDRWIDTH-1:0]   acc_row;
  logic [NUMBER_ADDRWIDTH-1:0]   acc_row_next;
  logic [NUMBER_COUNTWIDTH-1:0]  acc_cnt;
  logic [NUMBER_COUNTWIDTH-1:0]  acc_cnt_next;

  logic                          hit;
  logic [NUMBER_ADDRWIDTH-1:0]   hit_row;
  logic [NUMBER_COUNTWIDTH-1:0]  hit_count;
  logic                          game_over;

  logic [NUMBER_DATAWIDTH-1:0]   ovl;
  logic                          ovl_any;
  logic                          last_row;
  logic                          publish;

  // Number of set bits in one row of overlap. The result is zero-extended
  // to the count width so that it can be added directly to the accumulator.
  function automatic logic [NUMBER_COUNTWIDTH-1:0] popcount(
    input logic [NUMBER_DATAWIDTH-1:0] v
  );
    logic [NUMBER_COUNTWIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < NUMBER_DATAWIDTH; i++) begin
      c = c + NUMBER_COUNTWIDTH'(v[i]);
    end
    return c;
  endfunction

  assign ovl      = CC_COLLISION_obs_InBUS & CC_COLLISION_point_InBUS;
  assign ovl_any  = |ovl;
  assign last_row = (row_addr == LAST_ROW);

  // Results are published on the edge that leaves the last SCAN row.
  // On that edge the outputs take the accumulator values that already
  // include the final row.
  assign publish  = (state == SCAN) && last_row;

  // Next-state and accumulator logic. The accumulators advance only while
  // scanning. They are cleared when a start is accepted, so a stale scan
  // cannot leak into the next result.
  always_comb begin
    state_next    = state;
    row_addr_next = row_addr;
    acc_hit_next  = acc_hit;
    acc_row_next  = acc_row;
    acc_cnt_next  = acc_cnt;

    case (state)
      IDLE: begin
        row_addr_next = '0;
        if (CC_COLLISION_start_InHigh) begin
          state_next   = SCAN;
          acc_hit_next = 1'b0;
          acc_row_next = '0;
          acc_cnt_next = '0;
        end
      end

      SCAN: begin
        // Only the first overlapping row is recorded. Later hits are
        // added to the count but do not move the reported row.
        if (ovl_any && !acc_hit) begin
          acc_row_next = row_addr;
        end
        if (ovl_any) begin
          acc_hit_next = 1'b1;
        end
        acc_cnt_next = acc_cnt + popcount(ovl);
        if (last_row) begin
          state_next    = DONE;
          row_addr_next = '0;
        end else begin
          row_addr_next = row_addr + 1'b1;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next    = IDLE;
        row_addr_next = '0;
      end
    endcase
  end

  // State, row pointer and accumulator registers.
  always_ff @(posedge CC_COLLISION_CLOCK_50 or negedge CC_COLLISION_RESET_InLow) begin
    if (!CC_COLLISION_RESET_InLow) begin
      state    <= IDLE;
      row_addr <= '0;
      acc_hit  <= 1'b0;
      acc_row  <= '0;
      acc_cnt  <= '0;
    end else begin
      state    <= state_next;
      row_addr <= row_addr_next;
      acc_hit  <= acc_hit_next;
      acc_row  <= acc_row_next;
      acc_cnt  <= acc_cnt_next;
    end
  end

  // Published results. They hold between scans, so the game controller
  // can read them at any time after a done pulse.
  always_ff @(posedge CC_COLLISION_CLOCK_50 or negedge CC_COLLISION_RESET_InLow) begin
    if (!CC_COLLISION_RESET_InLow) begin
      hit       <= 1'b0;
      hit_row   <= '0;
      hit_count <= '0;
    end else if (publish) begin
      hit       <= acc_hit_next;
      hit_row   <= acc_row_next;
      hit_count <= acc_cnt_next;
    end
  end

  // Sticky game-over flag. A hit being published takes priority over a
  // clear on the same edge, so a collision is never silently lost.
  always_ff @(posedge CC_COLLISION_CLOCK_50 or negedge CC_COLLISION_RESET_InLow) begin
    if (!CC_COLLISION_RESET_InLow) begin
      game_over <= 1'b0;
    end else if (publish && acc_hit_next) begin
      game_over <= 1'b1;
    end else if (CC_COLLISION_clear_InHigh) begin
      game_over <= 1'b0;
    end
  end

  assign CC_COLLISION_rowAddr_OutBUS   = row_addr;
  assign CC_COLLISION_busy_OutHigh     = (state == SCAN);
  assign CC_COLLISION_done_OutHigh     = (state == DONE);
  assign CC_COLLISION_hit_OutHigh      = hit;
  assign CC_COLLISION_hitRow_OutBUS    = hit_row;
  assign CC_COLLISION_hitCount_OutBUS  = hit_count;
  assign CC_COLLISION_gameOver_OutHigh = game_over;

endmodule
